// File: rtl/modbus_rx_frame_fifo.sv
// Frame-aware receive byte FIFO between the Modbus UART bridge and the host RX port.
// Bytes are written speculatively and only become visible to the host once their frame commits.
module modbus_rx_frame_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_pclk,
  input  logic          i_presetn,
  input  logic          i_enable,
  input  logic          i_flush,
  input  logic [7:0]    i_in_data,
  input  logic          i_in_valid,
  input  logic          i_frame_start,
  input  logic          i_frame_end,
  output logic [7:0]    o_out_data,
  output logic          o_out_last,
  output logic          o_out_valid,
  input  logic          i_out_pop,
  output logic [AW:0]   o_level,
  output logic [AW:0]   o_frames_avail,
  output logic          o_overflow,
  input  logic          i_ovf_clr,
  output logic [7:0]    o_drop_cnt
);
  // state   | meaning
  // IDLE    | between frames, wr_ptr == cm_ptr
  // RECV    | frame arriving, bytes written speculatively past cm_ptr
  // DROP    | frame overflowed, discarding bytes until the next frame boundary
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_P   = (AW+1)'(1);

  logic [8:0]    r_mem [DEPTH];
  logic [1:0]    r_state;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_cm_ptr;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_frames;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic          w_recv;
  logic          w_full;
  logic          w_wr_en;
  logic          w_drop;
  logic          w_commit;
  logic          w_set_last;
  logic          w_pop;
  logic          w_pop_last;
  logic [AW:0]   w_base;
  logic [AW:0]   w_prev;
  logic [AW:0]   w_next_wr;
  logic [AW-1:0] w_mem_idx;
  logic [8:0]    w_mem_wdata;
  logic [8:0]    w_head;

  // A start pulse (or an implicit start from IDLE) rebases the frame on cm_ptr before the byte lands.
  assign w_base    = (i_frame_start || r_state == ST_IDLE) ? r_cm_ptr : r_wr_ptr;
  assign w_prev    = w_base - ONE_P;
  assign w_recv    = i_enable && !i_flush &&
                     (i_frame_start || r_state == ST_RECV || (r_state == ST_IDLE && i_in_valid));
  assign w_full    = (w_base - r_rd_ptr) == DEPTH_P;
  assign w_wr_en   = w_recv && i_in_valid && !w_full;
  assign w_drop    = w_recv && i_in_valid && w_full;
  assign w_next_wr = w_wr_en ? (w_base + ONE_P) : w_base;
  assign w_commit  = w_recv && i_frame_end && !w_drop && (w_next_wr != r_cm_ptr);
  assign w_set_last = w_commit && !w_wr_en;

  assign w_mem_idx   = w_wr_en ? w_base[AW-1:0] : w_prev[AW-1:0];
  assign w_mem_wdata = w_wr_en ? {i_frame_end, i_in_data} : {1'b1, r_mem[w_prev[AW-1:0]][7:0]};

  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign o_out_valid = r_rd_ptr != r_cm_ptr;
  assign o_out_data  = o_out_valid ? w_head[7:0] : 8'h00;
  assign o_out_last  = o_out_valid ? w_head[8] : 1'b0;
  assign w_pop       = i_out_pop && o_out_valid && !i_flush;
  assign w_pop_last  = w_pop && w_head[8];

  assign o_level        = r_cm_ptr - r_rd_ptr;
  assign o_frames_avail = r_frames;
  assign o_overflow     = r_overflow;
  assign o_drop_cnt     = r_drop_cnt;

  always_ff @(posedge i_pclk) begin
    if (i_presetn && (w_wr_en || w_set_last)) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_presetn) begin
      r_state    <= ST_IDLE;
      r_rd_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_frames   <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else begin
      if (i_flush) begin
        r_state  <= ST_IDLE;
        r_rd_ptr <= '0;
        r_cm_ptr <= '0;
        r_wr_ptr <= '0;
        r_frames <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + ONE_P;
        end
        if (w_commit) begin
          r_cm_ptr <= w_next_wr;
        end
        r_frames <= r_frames + (AW+1)'(w_commit) - (AW+1)'(w_pop_last);
        if (!i_enable) begin
          r_wr_ptr <= r_cm_ptr;
          r_state  <= ST_IDLE;
        end else if (w_drop) begin
          r_wr_ptr <= r_cm_ptr;
          r_state  <= i_frame_end ? ST_IDLE : ST_DROP;
        end else if (w_recv) begin
          r_wr_ptr <= w_next_wr;
          r_state  <= i_frame_end ? ST_IDLE : ST_RECV;
        end else if (r_state == ST_DROP && i_frame_end) begin
          r_state <= ST_IDLE;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'h01;
        end
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modbus_rx_frame_fifo.sv
// Bench for modbus_rx_frame_fifo: queue-based frame model plus a scoreboard monitor on the host port.
module tb_modbus_rx_frame_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          rstn, en, fl, v, fs, fe, pop, oc;
  logic [7:0]    din;
  logic [7:0]    o_out_data;
  logic          o_out_last, o_out_valid, o_overflow;
  logic [AW:0]   o_level, o_frames_avail;
  logic [7:0]    o_drop_cnt;

  modbus_rx_frame_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_pclk(clk), .i_presetn(rstn), .i_enable(en), .i_flush(fl),
    .i_in_data(din), .i_in_valid(v), .i_frame_start(fs), .i_frame_end(fe),
    .o_out_data(o_out_data), .o_out_last(o_out_last), .o_out_valid(o_out_valid),
    .i_out_pop(pop), .o_level(o_level), .o_frames_avail(o_frames_avail),
    .o_overflow(o_overflow), .i_ovf_clr(oc), .o_drop_cnt(o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: committed bytes {last,data}, bytes of the frame in progress, and counters.
  logic [8:0] mq[$];
  logic [8:0] exp_q[$];
  logic [7:0] part[$];
  int         m_frames, m_dcnt, m_st;   // m_st: 0 between frames, 1 receiving, 2 discarding
  bit         m_ovf;
  bit         mon_on;
  int         n_pass, n_checks;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_edge();
    bit dropped = 0;
    bit recv;
    bit pop_ok;
    logic [8:0] head = '0;
    logic [8:0] e;
    if (!rstn) begin
      mq.delete(); exp_q.delete(); part.delete();
      m_frames = 0; m_ovf = 0; m_dcnt = 0; m_st = 0;
      return;
    end
    if (fl) begin
      mq.delete(); exp_q.delete(); part.delete();
      m_frames = 0; m_st = 0;
      if (oc) m_ovf = 0;
      return;
    end
    pop_ok = pop && (mq.size() > 0);
    if (pop_ok) head = mq[0];
    if (en) begin
      recv = fs || m_st == 1 || (m_st == 0 && v);
      if (fs) part.delete();
      if (recv) begin
        if (v) begin
          if (mq.size() + part.size() >= DEPTH) begin
            dropped = 1;
            part.delete();
            m_ovf = 1;
            if (m_dcnt < 255) m_dcnt++;
            m_st = fe ? 0 : 2;
          end else begin
            part.push_back(din);
          end
        end
        if (!dropped) begin
          m_st = 1;
          if (fe) begin
            if (part.size() > 0) begin
              for (int i = 0; i < part.size(); i++) begin
                e = {(i == part.size() - 1), part[i]};
                mq.push_back(e);
                exp_q.push_back(e);
              end
              m_frames++;
            end
            part.delete();
            m_st = 0;
          end
        end
      end else if (m_st == 2 && fe) begin
        m_st = 0;
      end
    end else begin
      part.delete();
      m_st = 0;
    end
    if (oc && !dropped) m_ovf = 0;
    if (pop_ok) begin
      void'(mq.pop_front());
      if (head[8]) m_frames--;
    end
  endtask

  // Monitor: status against the model every cycle; popped bytes against the scoreboard queue.
  always @(negedge clk) begin
    logic [8:0] e;
    if (mon_on) begin
      chk("out_valid", o_out_valid, mq.size() != 0);
      chk("level", o_level, mq.size());
      chk("frames_avail", o_frames_avail, m_frames);
      chk("overflow", o_overflow, m_ovf);
      chk("drop_cnt", o_drop_cnt, m_dcnt);
      if (!o_out_valid) begin
        chk("idle_out", {o_out_last, o_out_data}, 0);
      end else if (pop) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pop_byte", {o_out_last, o_out_data}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    v = 0; fs = 0; fe = 0; pop = 0; fl = 0; oc = 0;
  endtask

  task automatic start_f();  fs = 1; step(); endtask
  task automatic end_f();    fe = 1; step(); endtask
  task automatic put(input logic [7:0] d); din = d; v = 1; step(); endtask
  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin pop = 1; step(); end
  endtask

  initial begin
    n_pass = 0; n_checks = 0; mon_on = 0;
    rstn = 0; en = 1; fl = 0; v = 0; fs = 0; fe = 0; pop = 0; oc = 0; din = 8'h00;
    step();
    mon_on = 1;
    step();
    rstn = 1;
    chk("rst_valid", o_out_valid, 0);
    chk("rst_level", o_level, 0);
    chk("rst_frames", o_frames_avail, 0);

    // basic six-byte frame
    start_f();
    put(8'h01); put(8'h03); put(8'h00); put(8'h00); put(8'h00); put(8'h02);
    chk("t1_precommit_valid", o_out_valid, 0);
    end_f();
    chk("t1_level", o_level, 6);
    chk("t1_frames", o_frames_avail, 1);
    chk("t1_head", o_out_data, 8'h01);
    pop_n(6);
    chk("t1_empty", o_out_valid, 0);
    chk("t1_frames0", o_frames_avail, 0);

    // nine bytes into eight entries, then an intact frame
    start_f();
    for (int i = 0; i < 9; i++) put(8'h10 + 8'(i));
    end_f();
    chk("t2_ovf", o_overflow, 1);
    chk("t2_drop", o_drop_cnt, 1);
    chk("t2_level", o_level, 0);
    start_f(); put(8'hAA); put(8'hBB); put(8'hCC); end_f();
    chk("t2_level3", o_level, 3);
    pop_n(3);
    oc = 1; step();
    chk("t2_ovf_clr", o_overflow, 0);

    // resync mid-frame
    start_f(); put(8'h21); put(8'h22); put(8'h23); put(8'h24); end_f();
    start_f(); put(8'h31); put(8'h32);
    start_f(); put(8'h41); put(8'h42); put(8'h43); end_f();
    chk("t3_frames", o_frames_avail, 2);
    chk("t3_level", o_level, 7);
    pop_n(7);

    // end with same-cycle byte; zero-byte frame
    start_f(); put(8'h11);
    din = 8'h55; v = 1; fe = 1; step();
    chk("t4_frames", o_frames_avail, 1);
    chk("t4_level", o_level, 2);
    start_f(); end_f();
    chk("t4_zero_frame", o_frames_avail, 1);
    pop_n(1);
    chk("t4_last", {o_out_last, o_out_data}, 9'h155);
    pop_n(1);

    // last-byte pop coincides with commit
    start_f(); put(8'hA1); put(8'hA2); end_f();
    pop_n(1);
    start_f(); put(8'hB1); put(8'hB2);
    fe = 1; pop = 1; step();
    chk("t5_frames", o_frames_avail, 1);
    chk("t5_head", o_out_data, 8'hB1);
    pop_n(2);

    // flush and disable mid-frame
    start_f(); put(8'h61); put(8'h62); put(8'h63);
    fl = 1; step();
    chk("t6_flush_level", o_level, 0);
    chk("t6_flush_drop", o_drop_cnt, 1);
    start_f(); put(8'h71); put(8'h72);
    en = 0; step(); en = 1;
    end_f();
    chk("t6_dis_frames", o_frames_avail, 0);
    chk("t6_dis_level", o_level, 0);

    // reset mid-frame
    start_f(); put(8'h81); end_f();
    start_f(); put(8'h91);
    rstn = 0; step(); rstn = 1;
    chk("t7_valid", o_out_valid, 0);
    chk("t7_drop", o_drop_cnt, 0);

    // drop counter saturation
    for (int k = 0; k < 260; k++) begin
      start_f();
      for (int i = 0; i < 9; i++) put(8'(k + i));
      end_f();
    end
    chk("t8_sat", o_drop_cnt, 255);
    fl = 1; step();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rstn = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      en   = ($urandom_range(0, 99) >= 4);
      fl   = ($urandom_range(0, 199) == 0);
      fs   = ($urandom_range(0, 99) < 6);
      fe   = ($urandom_range(0, 99) < 8);
      v    = ($urandom_range(0, 99) < 55);
      din  = 8'($urandom);
      pop  = ($urandom_range(0, 99) < 45);
      oc   = ($urandom_range(0, 99) < 3);
      step();
    end
    rstn = 1; en = 1;
    pop_n(DEPTH + 2);
    chk("final_empty", o_out_valid, 0);

    mon_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/modbus_rx_frame_fifo.md
Name: modbus_rx_frame_fifo

Overview:
- Frame-aware receive buffer between the UART bridge's received-byte stream and the CSR block's host RX message port (rx_data/rx_valid/rx_pop).
- Bytes are written speculatively while a frame is arriving. They become visible to the host only when the frame completes.
- Partial frames, aborted frames and overflowed frames are discarded whole. The host never reads a torn frame.

Parameters:
- DEPTH, 64, byte storage entries; power of two, minimum 4.
- AW, 6, log2(DEPTH); pointers are AW+1 bits.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  synchronous active-low reset.
- enable  in  1  accept bridge traffic when 1.
- flush  in  1  synchronous clear of buffer contents.
- in_data  in  8  received byte from bridge.
- in_valid  in  1  in_data valid (single-cycle pulse).
- frame_start  in  1  bridge start-of-frame pulse.
- frame_end  in  1  bridge end-of-frame pulse (silence/terminator detected).
- out_data  out  8  head byte, first-word-fall-through.
- out_last  out  1  head byte is the final byte of its frame.
- out_valid  out  1  committed byte available.
- out_pop  in  1  consume head byte.
- level  out  AW+1  committed bytes held.
- frames_avail  out  AW+1  complete frames held.
- overflow  out  1  sticky; a frame was dropped for lack of space.
- ovf_clr  in  1  clears overflow.
- drop_cnt  out  8  frames dropped, saturating at 255.

Behaviour:
- Everything updates on rising PCLK.
- Reset (PRESETn=0) values: all pointers 0; state IDLE; out_valid=0; out_data=0; out_last=0; level=0; frames_avail=0; overflow=0; drop_cnt=0. Storage is not reset.
- Pointers:
  - rd_ptr: host read pointer.
  - cm_ptr: commit pointer.
  - wr_ptr: speculative write pointer.
  - All wrap modulo 2*DEPTH; index is ptr[AW-1:0].
  - Full when wr_ptr - rd_ptr == DEPTH.
- Each entry stores {last, data}.
- States:
  - IDLE:
    - frame_start -> RECV, with wr_ptr <= cm_ptr.
    - in_valid without a prior frame_start implicitly starts a frame: the byte is stored as the first byte, -> RECV.
  - RECV:
    - in_valid and not full: write {0,in_data} at wr_ptr; wr_ptr++.
    - in_valid and full: wr_ptr <= cm_ptr; overflow <= 1; drop_cnt++ (saturating); -> DROP.
    - frame_end with wr_ptr != cm_ptr: set last bit of entry wr_ptr-1; cm_ptr <= wr_ptr; frames_avail++; -> IDLE.
    - frame_end with wr_ptr == cm_ptr (zero-byte frame): no commit, no count; -> IDLE.
    - frame_start (re-sync): discard partial frame (wr_ptr <= cm_ptr), stay RECV.
  - DROP:
    - Ignore in_valid.
    - frame_end -> IDLE without commit.
    - frame_start -> RECV with wr_ptr <= cm_ptr.
- Same-cycle events:
  - frame_start+in_valid: start is processed first; the byte becomes the first byte of the new frame.
  - frame_end+in_valid in RECV, not full: the byte is written with last=1 and included in the commit (cm_ptr <= wr_ptr+1).
  - frame_end+in_valid in RECV, full: the frame is dropped, counted once, -> IDLE.
- Read side:
  - out_valid = (rd_ptr != cm_ptr).
  - out_data/out_last come from entry rd_ptr; both are forced to 0 when out_valid=0.
  - out_pop with out_valid: rd_ptr++. If out_last, frames_avail--.
  - out_pop with out_valid=0 is ignored.
  - Commit and last-byte pop in the same cycle: frames_avail is net unchanged. The new head byte is visible the following cycle.
  - level = cm_ptr - rd_ptr. Speculative bytes are never counted.
- A pop in the same cycle as a full-detect frees space only from the next cycle; the full decision uses pre-edge pointers.
- enable=0: in_valid/frame_start/frame_end are ignored. Any partial frame is rolled back (wr_ptr <= cm_ptr), -> IDLE. The read side is unaffected.
- flush: rd_ptr=cm_ptr=wr_ptr=0, frames_avail=0, -> IDLE. overflow and drop_cnt are retained. flush has priority over all same-cycle events except reset.
- ovf_clr: overflow <= 0 unless a new drop occurs in the same cycle (set wins).

Test Plan:
- Reset, then frame_start, bytes 01 03 00 00 00 02, frame_end -> out_valid 1 cycle later, level=6, frames_avail=1. Six pops return 01,03,00,00,00,02 with out_last only on 02. frames_avail=0, out_valid=0.
- DEPTH=8, frame of 9 bytes -> overflow=1, drop_cnt=1, level=0, no out_valid. A following 3-byte frame AA BB CC is committed and read intact.
- Frame of 4 bytes, then frame_start again after 2 bytes of the next frame, then 3 bytes and frame_end -> frames_avail=2, level=7, second frame contains only the 3 post-resync bytes.
- frame_end with in_valid=1, in_data=55 on the same cycle -> 55 committed with out_last=1. frame_end with no bytes -> frames_avail unchanged.
- Host pops the last byte of frame A on the same cycle frame B commits -> frames_avail stays 1, the head switches to B's first byte next cycle.
- Mid-frame flush or enable=0 -> level=0, frames_avail=0, overflow/drop_cnt unchanged. Mid-frame PRESETn=0 -> all outputs return to reset values on the next edge.
